// File: rtl/debug_trace_buffer.sv
// debug_trace_buffer: captures one entry per new PC from the core debug port into a circular FIFO
// read over valid/ready; capture halts once the stop instruction is recorded.
module debug_trace_buffer #(
    parameter int          DEPTH      = 16,
    parameter logic [31:0] STOP_INSTR = 32'h0000_0073,
    parameter int          DROP_W     = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     trace_enable,
    input  logic                     clear,
    input  logic [63:0]              debug_pc,
    input  logic [31:0]              debug_instruction,
    input  logic [63:0]              debug_alu_result,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [63:0]              rd_pc,
    output logic [31:0]              rd_instruction,
    output logic [63:0]              rd_alu_result,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic [DROP_W-1:0]        drop_count,
    output logic [1:0]               state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE = 2'd0, CAPTURE = 2'd1, STOPPED = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [63:0]     pc_mem    [DEPTH];
    logic [31:0]     instr_mem [DEPTH];
    logic [63:0]     alu_mem   [DEPTH];
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [AW:0]     count_q;
    logic            first_flag;
    logic [63:0]     last_pc;
    logic            is_new, pop, push, drop, stop_hit;

    always_comb begin
        is_new   = state_q == CAPTURE && trace_enable && !clear && (first_flag || debug_pc != last_pc);
        pop      = count_q != '0 && rd_ready && !clear;
        push     = is_new && (count_q < FULL || pop);
        drop     = is_new && !push;
        stop_hit = is_new && debug_instruction == STOP_INSTR;
        state_d  = clear ? IDLE :
                   state_q == IDLE    ? (trace_enable ? CAPTURE : IDLE) :
                   state_q == CAPTURE ? (!trace_enable ? IDLE : stop_hit ? STOPPED : CAPTURE) :
                   STOPPED;
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                pc_mem[i]    <= '0;
                instr_mem[i] <= '0;
                alu_mem[i]   <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            first_flag <= 1'b1;
            last_pc    <= '0;
        end else if (clear) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count_q    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            first_flag <= 1'b1;
            last_pc    <= '0;
        end else begin
            if (push) begin
                pc_mem[wr_ptr]    <= debug_pc;
                instr_mem[wr_ptr] <= debug_instruction;
                alu_mem[wr_ptr]   <= debug_alu_result;
                wr_ptr            <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop);
            if (drop) begin
                overflow   <= 1'b1;
                drop_count <= &drop_count ? drop_count : drop_count + 1'b1;
            end
            if (is_new) begin
                last_pc    <= debug_pc;
                first_flag <= 1'b0;
            end
            // leaving capture forces the next PC after re-arming to be recorded
            if (state_q == CAPTURE && !trace_enable) first_flag <= 1'b1;
        end
    end

    assign rd_valid       = count_q != '0;
    assign rd_pc          = pc_mem[rd_ptr];
    assign rd_instruction = instr_mem[rd_ptr];
    assign rd_alu_result  = alu_mem[rd_ptr];
    assign count          = count_q;
    assign state          = state_q;
endmodule

// File: tb/tb_debug_trace_buffer.sv
// tb_debug_trace_buffer: directed and randomized checks of debug_trace_buffer against a queue-based model.
module tb_debug_trace_buffer;
    localparam int DEPTH = 16;
    localparam logic [31:0] STOP = 32'h0000_0073;

    logic        clk = 0, reset = 0, trace_enable = 0, clear = 0, rd_ready = 0;
    logic [63:0] debug_pc = 0, debug_alu_result = 0;
    logic [31:0] debug_instruction = 0;
    logic        rd_valid, overflow;
    logic [63:0] rd_pc, rd_alu_result;
    logic [31:0] rd_instruction;
    logic [4:0]  count;
    logic [15:0] drop_count;
    logic [1:0]  state;

    debug_trace_buffer #(.DEPTH(DEPTH), .STOP_INSTR(STOP), .DROP_W(16)) dut (
        .clk(clk), .reset(reset), .trace_enable(trace_enable), .clear(clear),
        .debug_pc(debug_pc), .debug_instruction(debug_instruction), .debug_alu_result(debug_alu_result),
        .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_pc(rd_pc), .rd_instruction(rd_instruction),
        .rd_alu_result(rd_alu_result), .count(count), .overflow(overflow), .drop_count(drop_count),
        .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {logic [63:0] pc; logic [31:0] instr; logic [63:0] alu;} entry_t;
    entry_t      q[$];
    int          m_state;
    bit          m_first, m_ov;
    logic [63:0] m_last;
    int          m_drops;
    int          n_checks = 0, n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_state = 0; m_first = 1; m_ov = 0; m_last = 0; m_drops = 0;
    endtask

    task automatic model_edge();
        bit pop_v, new_v, push_v;
        entry_t e;
        if (clear) begin
            model_reset();
            return;
        end
        pop_v  = q.size() > 0 && rd_ready;
        new_v  = m_state == 1 && trace_enable && (m_first || debug_pc != m_last);
        push_v = new_v && (q.size() < DEPTH || pop_v);
        if (pop_v) void'(q.pop_front());
        if (push_v) begin
            e.pc = debug_pc; e.instr = debug_instruction; e.alu = debug_alu_result;
            q.push_back(e);
        end
        if (new_v && !push_v) begin
            m_ov = 1;
            if (m_drops < 65535) m_drops++;
        end
        if (new_v) begin
            m_last = debug_pc; m_first = 0;
        end
        if (m_state == 0) m_state = trace_enable ? 1 : 0;
        else if (m_state == 1) begin
            if (!trace_enable) begin m_state = 0; m_first = 1; end
            else if (new_v && debug_instruction == STOP) m_state = 2;
        end
    endtask

    task automatic check_model();
        check("count", 64'(count), 64'(q.size()));
        check("rd_valid", 64'(rd_valid), 64'(q.size() != 0));
        check("state", 64'(state), 64'(m_state));
        check("overflow", 64'(overflow), 64'(m_ov));
        check("drop_count", 64'(drop_count), 64'(m_drops));
        if (q.size() != 0) begin
            check("rd_pc", rd_pc, q[0].pc);
            check("rd_instruction", 64'(rd_instruction), 64'(q[0].instr));
            check("rd_alu_result", rd_alu_result, q[0].alu);
        end
    endtask

    task automatic step(input logic te, input logic [63:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic clr);
        trace_enable = te; debug_pc = pc; debug_instruction = ins; rd_ready = rdy; clear = clr;
        debug_alu_result = {$urandom, $urandom};
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        model_reset();
        reset = 1;
        #12;
        check("reset_count", 64'(count), 0);
        check("reset_valid", 64'(rd_valid), 0);
        check("reset_state", 64'(state), 0);
        check("reset_rd_pc", rd_pc, 0);
        @(negedge clk);
        reset = 0;

        step(1, 64'h99, 0, 0, 0);
        step(1, 64'h0, 32'h00500093, 0, 0);
        step(1, 64'h4, 32'h00300113, 0, 0);
        step(1, 64'h8, 32'h002081b3, 0, 0);
        check("seq_count", 64'(count), 3);
        check("seq_head_pc", rd_pc, 0);
        check("seq_head_instr", 64'(rd_instruction), 64'h00500093);
        check("seq_state", 64'(state), 1);

        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 64'h10, 32'h13, 0, 0);
        step(1, 64'h14, 32'h13, 0, 0);
        check("stall_count", 64'(count), 2);
        check("stall_pop0", rd_pc, 64'h10);
        step(1, 64'h14, 32'h13, 1, 0);
        check("stall_pop1", rd_pc, 64'h14);
        step(1, 64'h14, 32'h13, 1, 0);
        check("stall_empty", 64'(rd_valid), 0);

        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) step(1, 64'h100 + 64'(4 * i), 32'h13, 0, 0);
        check("full_count", 64'(count), 16);
        check("full_overflow", 64'(overflow), 1);
        check("full_drops", 64'(drop_count), 4);
        check("full_head", rd_pc, 64'h100);
        step(1, 64'h200, 32'h13, 1, 0);
        check("full_pp_count", 64'(count), 16);
        check("full_pp_drops", 64'(drop_count), 4);
        check("full_pp_head", rd_pc, 64'h104);

        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);
        step(1, 64'h40, STOP, 0, 0);
        check("stop_state", 64'(state), 2);
        check("stop_count", 64'(count), 1);
        step(1, 64'h44, 32'h13, 0, 0);
        step(1, 64'h48, 32'h13, 0, 0);
        check("stop_hold", 64'(count), 1);
        check("stop_head", 64'(rd_instruction), 64'(STOP));
        step(1, 0, 0, 0, 1);
        check("clr_count", 64'(count), 0);
        check("clr_state", 64'(state), 0);
        check("clr_overflow", 64'(overflow), 0);

        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) step(1, 64'h300 + 64'(4 * i), 32'h13, 0, 0);
        check("pre_rst_count", 64'(count), 5);
        #2 reset = 1;
        #1;
        check("async_count", 64'(count), 0);
        check("async_valid", 64'(rd_valid), 0);
        check("async_state", 64'(state), 0);
        model_reset();
        @(negedge clk);
        reset = 0;

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 9) != 0, 64'({$urandom_range(0, 7), 2'b00}),
                 $urandom_range(0, 15) == 0 ? STOP : $urandom,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 63) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
